// File: rtl/sha256_pkg.sv
// Shared types, sizing constants and sigma helpers for the SHA-256 message schedule.
// Both sigma functions use fixed bit-slice rotations so they reduce to pure wiring plus XOR.
package sha256_pkg;

  localparam int ROUNDS   = 64;
  localparam int WORDS_IN = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b00_0000_0000, x[31:10]};
  endfunction

endpackage

// File: rtl/adder_32b_param.sv
// Plain ripple/inferred adder with carry in and carry out.
// Width is a parameter; the carry out is the bit above the sum.
module adder_32b_param #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  // Extend every operand by one bit so the carry lands in the top bit
  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_carry};

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 message words into a 16-slot sliding window,
// then streams W[0..63] with valid/ready handshaking, expanding new words on each transfer.
module sha256_msg_schedule #(
  parameter int ROUNDS   = 64,
  parameter int WORDS_IN = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_word_valid,
  input  logic [31:0] i_word,
  output logic        o_word_ready,
  output logic        o_w_valid,
  input  logic        i_w_ready,
  output logic [31:0] o_w,
  output logic [5:0]  o_round,
  output logic        o_busy,
  output logic        o_done
);

  import sha256_pkg::*;

  state_e             state_r;
  state_e             state_next_s;
  logic [15:0][31:0]  win_r;
  logic [5:0]         t_r;
  logic [3:0]         load_cnt_r;
  logic               load_fire_s;
  logic               xfer_s;
  logic               word_ready_r;
  logic               w_valid_r;
  logic               busy_r;
  logic               done_r;

  logic [31:0]        s0_s;
  logic [31:0]        s1_s;
  logic [31:0]        sum_a_s;
  logic [31:0]        sum_b_s;
  logic [31:0]        w_new_s;
  logic [31:0]        shift_in_s;
  logic [2:0]         carry_unused_s;

  assign s0_s = sigma0(win_r[1]);
  assign s1_s = sigma1(win_r[14]);

  adder_32b_param #(.WIDTH(32)) u_add_s1_w9 (
    .i_a     (s1_s),
    .i_b     (win_r[9]),
    .i_carry (1'b0),
    .o_sum   (sum_a_s),
    .o_carry (carry_unused_s[0])
  );

  adder_32b_param #(.WIDTH(32)) u_add_s0_w0 (
    .i_a     (s0_s),
    .i_b     (win_r[0]),
    .i_carry (1'b0),
    .o_sum   (sum_b_s),
    .o_carry (carry_unused_s[1])
  );

  adder_32b_param #(.WIDTH(32)) u_add_final (
    .i_a     (sum_a_s),
    .i_b     (sum_b_s),
    .i_carry (1'b0),
    .o_sum   (w_new_s),
    .o_carry (carry_unused_s[2])
  );

  // Next-state decode plus the load/transfer strobes
  always_comb begin
    state_next_s = state_r;
    load_fire_s  = 1'b0;
    xfer_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (i_word_valid) begin
          load_fire_s = 1'b1;
          if (load_cnt_r == 4'(WORDS_IN - 1)) begin
            state_next_s = ST_EXPAND;
          end else begin
            state_next_s = ST_LOAD;
          end
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_EXPAND: begin
        if (i_w_ready) begin
          xfer_s = 1'b1;
          if (t_r == 6'(ROUNDS - 1)) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_EXPAND;
          end
        end else begin
          state_next_s = ST_EXPAND;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Slot 15 takes the incoming message word while loading, the expanded word otherwise
  always_comb begin
    shift_in_s = 32'h0000_0000;
    if (load_fire_s) begin
      shift_in_s = i_word;
    end else begin
      shift_in_s = w_new_s;
    end
  end

  // State register and output flags, registered from the next state so they align with it
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r      <= ST_IDLE;
      word_ready_r <= 1'b0;
      w_valid_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      word_ready_r <= (state_next_s == ST_LOAD);
      w_valid_r    <= (state_next_s == ST_EXPAND);
      busy_r       <= (state_next_s == ST_LOAD) || (state_next_s == ST_EXPAND);
      done_r       <= (state_next_s == ST_DONE);
    end
  end

  // Sliding window: shift down one slot per accepted load word or per transfer
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      win_r <= '0;
    end else if (load_fire_s || xfer_s) begin
      win_r <= {shift_in_s, win_r[15:1]};
    end
  end

  // Load count and round index; t is held at zero until expansion starts
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      load_cnt_r <= 4'd0;
      t_r        <= 6'd0;
    end else begin
      if (state_r == ST_IDLE) begin
        load_cnt_r <= 4'd0;
      end else if (load_fire_s) begin
        load_cnt_r <= load_cnt_r + 4'd1;
      end
      if (state_r == ST_IDLE || state_r == ST_LOAD) begin
        t_r <= 6'd0;
      end else if (xfer_s) begin
        t_r <= t_r + 6'd1;
      end
    end
  end

  assign o_word_ready = word_ready_r;
  assign o_w_valid    = w_valid_r;
  assign o_busy       = busy_r;
  assign o_done       = done_r;
  assign o_w          = win_r[0];
  assign o_round      = t_r;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: a reference expansion fills a scoreboard queue at
// load time and a negedge monitor pops and compares every transferred W word.
module tb_sha256_msg_schedule;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic        i_word_valid;
  logic [31:0] i_word;
  logic        o_word_ready;
  logic        o_w_valid;
  logic        i_w_ready;
  logic [31:0] o_w;
  logic [5:0]  o_round;
  logic        o_busy;
  logic        o_done;

  sha256_msg_schedule #(.ROUNDS(64), .WORDS_IN(16)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_word_valid (i_word_valid),
    .i_word       (i_word),
    .o_word_ready (o_word_ready),
    .o_w_valid    (o_w_valid),
    .i_w_ready    (i_w_ready),
    .o_w          (o_w),
    .o_round      (o_round),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [5:0]  round;
    logic [31:0] w;
  } exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        exp_q[$];
  logic [31:0] obs_w [64];
  logic [31:0] blk_abc [16];
  logic [31:0] blk_ones [16];
  bit          aborted;

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 64; i++) obs_w[i] = 32'h0000_0000;
  endtask

  // Scoreboard consumer: every handshake transfer is compared with the next expected word
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst_n === 1'b1 && o_w_valid === 1'b1 && i_w_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL w_unexpected: observed round %0d expected no transfer", o_round);
      end else begin
        e = exp_q.pop_front();
        chk("w_round", 32'(o_round), 32'(e.round));
        chk("w_data", o_w, e.w);
        obs_w[o_round] = o_w;
      end
    end
  end

  task automatic push_expected(input logic [31:0] m [16]);
    logic [31:0] w [64];
    exp_t        e;
    for (int i = 0; i < 16; i++) w[i] = m[i];
    for (int i = 16; i < 64; i++)
      w[i] = ref_s1(w[i-2]) + w[i-7] + ref_s0(w[i-15]) + w[i-16];
    for (int i = 0; i < 64; i++) begin
      e.round = 6'(i);
      e.w     = w[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic load_block(input logic [31:0] m [16], input bit gaps);
    push_expected(m);
    i_w_ready = 1'b1;
    i_start   = 1'b1;
    tick();
    i_start = 1'b0;
    chk("load_ready", 32'(o_word_ready), 32'd1);
    chk("load_busy", 32'(o_busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (gaps && (i % 3) != 0) begin
        i_word_valid = 1'b0;
        i_word       = 32'hDEAD_BEEF;
        tick();
        chk("gap_no_valid", 32'(o_w_valid), 32'd0);
      end
      i_word_valid = 1'b1;
      i_word       = m[i];
      tick();
      if (i < 15) chk("load_no_valid", 32'(o_w_valid), 32'd0);
    end
    i_word_valid = 1'b0;
    i_word       = 32'hDEAD_BEEF;
    chk("w0_valid", 32'(o_w_valid), 32'd1);
    chk("w0_round", 32'(o_round), 32'd0);
  endtask

  task automatic run_expand(input int stall_at, input int start_at, input int rst_at,
                            input bit start_in_done, output bit got_reset);
    int          cyc;
    bit          stalled;
    logic [31:0] held_exp;
    cyc       = 0;
    stalled   = 1'b0;
    got_reset = 1'b0;
    i_w_ready = 1'b1;
    while (o_done !== 1'b1 && cyc < 300) begin
      if (rst_at >= 0 && o_round == 6'(rst_at)) begin
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        chk("rst_w_valid", 32'(o_w_valid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_round", 32'(o_round), 32'd0);
        chk("rst_w", o_w, 32'd0);
        exp_q.delete();
        got_reset = 1'b1;
        return;
      end
      if (stall_at >= 0 && !stalled && o_round == 6'(stall_at)) begin
        stalled   = 1'b1;
        held_exp  = exp_q[0].w;
        i_w_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick();
          chk("stall_w", o_w, held_exp);
          chk("stall_round", 32'(o_round), 32'(stall_at));
          cyc++;
        end
        i_w_ready = 1'b1;
      end
      i_start = (start_at >= 0 && o_round == 6'(start_at)) ? 1'b1 : 1'b0;
      tick();
      cyc++;
    end
    i_start = 1'b0;
    chk("done_seen", 32'(o_done), 32'd1);
    chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
    i_start = start_in_done;
    tick();
    i_start = 1'b0;
    chk("done_pulse_end", 32'(o_done), 32'd0);
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("idle_word_ready", 32'(o_word_ready), 32'd0);
    chk("idle_w_valid", 32'(o_w_valid), 32'd0);
    tick();
    chk("idle_stays", 32'(o_busy), 32'd0);
  endtask

  initial begin
    blk_abc[0] = 32'h6162_6380;
    for (int i = 1; i < 15; i++) blk_abc[i] = 32'h0000_0000;
    blk_abc[15] = 32'h0000_0018;
    for (int i = 0; i < 16; i++) blk_ones[i] = 32'hFFFF_FFFF;

    i_rst_n      = 1'b0;
    i_start      = 1'b0;
    i_word_valid = 1'b0;
    i_word       = 32'h0000_0000;
    i_w_ready    = 1'b0;
    tick();
    tick();
    chk("reset_word_ready", 32'(o_word_ready), 32'd0);
    chk("reset_w_valid", 32'(o_w_valid), 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_done", 32'(o_done), 32'd0);
    chk("reset_w", o_w, 32'd0);
    chk("reset_round", 32'(o_round), 32'd0);
    i_rst_n = 1'b1;
    i_word_valid = 1'b1;
    tick();
    i_word_valid = 1'b0;
    chk("idle_ignores_word", 32'(o_busy), 32'd0);

    clear_obs();
    load_block(blk_abc, 1'b0);
    run_expand(-1, -1, -1, 1'b0, aborted);
    chk("abc_w0", obs_w[0], 32'h6162_6380);
    chk("abc_w15", obs_w[15], 32'h0000_0018);
    chk("abc_w16", obs_w[16], 32'h6162_6380);
    chk("abc_w17", obs_w[17], 32'h000F_0000);

    clear_obs();
    load_block(blk_ones, 1'b0);
    run_expand(-1, -1, -1, 1'b0, aborted);
    chk("ones_w16", obs_w[16], 32'h203F_FFFC);

    clear_obs();
    load_block(blk_abc, 1'b0);
    run_expand(20, -1, -1, 1'b0, aborted);
    chk("stall_abc_w17", obs_w[17], 32'h000F_0000);

    clear_obs();
    load_block(blk_ones, 1'b1);
    run_expand(-1, -1, -1, 1'b0, aborted);
    chk("gap_ones_w16", obs_w[16], 32'h203F_FFFC);

    clear_obs();
    load_block(blk_abc, 1'b0);
    run_expand(-1, -1, 30, 1'b0, aborted);
    chk("rst_taken", 32'(aborted), 32'd1);
    clear_obs();
    load_block(blk_abc, 1'b0);
    run_expand(-1, -1, -1, 1'b0, aborted);
    chk("post_rst_w0", obs_w[0], 32'h6162_6380);
    chk("post_rst_w15", obs_w[15], 32'h0000_0018);
    chk("post_rst_w16", obs_w[16], 32'h6162_6380);
    chk("post_rst_w17", obs_w[17], 32'h000F_0000);

    clear_obs();
    load_block(blk_abc, 1'b0);
    run_expand(-1, 10, -1, 1'b1, aborted);
    chk("start_ign_w17", obs_w[17], 32'h000F_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
